// File: rtl/mux_nw_scan_reg.sv
// N-channel, WIDTH-bit registered multiplexer with a valid/ready output stage.
// Channel comes from sel (manual) or from an internal pointer that sweeps 0..N-1 (scan).
module mux_nw_scan_reg #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   din,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    output logic                 frame_done
);

    // Handshake: an item moves to the consumer on any edge where out_valid and
    // out_ready are both high; a new item is captured when en is high and the
    // output register is empty or being emptied on that same edge.
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic [SELW-1:0]  scan_ptr;
    logic [SELW-1:0]  idx;
    logic [WIDTH-1:0] picked;
    logic             cap;

    assign idx = mode ? scan_ptr : sel;
    assign cap = en & (~out_valid | out_ready);

    // Indices with no matching channel (N not a power of two) select zero.
    always_comb begin
        picked = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) begin
                picked = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (cap) begin
            out        <= picked;
            out_ch     <= idx;
            out_valid  <= 1'b1;
            frame_done <= mode & (scan_ptr == LAST);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

    // Held at zero in manual mode so every scan frame begins at channel 0.
    always_ff @(posedge clk) begin
        if (rst || !mode) begin
            scan_ptr <= '0;
        end else if (cap) begin
            scan_ptr <= (scan_ptr == LAST) ? '0 : scan_ptr + SELW'(1);
        end
    end

endmodule

// File: tb/tb_mux_nw_scan_reg.sv
// Self-checking bench for mux_nw_scan_reg: directed vector table, hand sequences,
// randomized traffic against a queue-based reference model, plus an N=3 instance.
module tb_mux_nw_scan_reg;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;
    localparam int N3    = 3;
    localparam logic [N*WIDTH-1:0]  D4 = {8'h44, 8'h33, 8'h22, 8'h11};
    localparam logic [N3*WIDTH-1:0] D3 = {8'h33, 8'h22, 8'h11};

    // ---------------- clock / reset / DUTs ----------------
    logic                clk = 1'b0;
    logic                rst, en, mode, out_ready;
    logic [SELW-1:0]     sel;
    logic [N*WIDTH-1:0]  din;
    logic [WIDTH-1:0]    out;
    logic [SELW-1:0]     out_ch;
    logic                out_valid, frame_done;

    logic                rst3, en3, mode3, ready3;
    logic [SELW-1:0]     sel3;
    logic [N3*WIDTH-1:0] din3;
    logic [WIDTH-1:0]    out3;
    logic [SELW-1:0]     ch3;
    logic                valid3, fd3;

    always #5 clk = ~clk;

    mux_nw_scan_reg #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din),
        .out_ready(out_ready), .out(out), .out_ch(out_ch),
        .out_valid(out_valid), .frame_done(frame_done)
    );

    mux_nw_scan_reg #(.WIDTH(WIDTH), .N(N3)) dut3 (
        .clk(clk), .rst(rst3), .en(en3), .mode(mode3), .sel(sel3), .din(din3),
        .out_ready(ready3), .out(out3), .out_ch(ch3),
        .out_valid(valid3), .frame_done(fd3)
    );

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int fails  = 0;
    logic [WIDTH+SELW-1:0] exp_q[$];

    logic [WIDTH-1:0] m_out;
    logic [SELW-1:0]  m_ch;
    bit               m_valid, m_fd;
    int               m_count;   // captures made since scan mode was entered

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the N=4 DUT: scoreboard transfer, model update, output compare.
    task automatic step(input bit r, input bit e, input bit m, input logic [SELW-1:0] s,
                        input logic [N*WIDTH-1:0] d, input bit rd);
        logic [WIDTH+SELW-1:0] item;
        int c;
        rst = r; en = e; mode = m; sel = s; din = d; out_ready = rd;
        if (!r && out_valid && rd) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_item", {out_ch, out}, '1);
            end else begin
                item = exp_q.pop_front();
                check("sb_item", {out_ch, out}, item);
            end
        end
        if (r) begin
            m_out = '0; m_ch = '0; m_valid = 0; m_fd = 0; m_count = 0;
            exp_q.delete();
        end else begin
            if (e && (!m_valid || rd)) begin
                c       = m ? (m_count % N) : int'(s);
                m_out   = d[c*WIDTH +: WIDTH];
                m_ch    = SELW'(c);
                m_fd    = m && (c == N - 1);
                m_valid = 1;
                if (m) m_count++;
                exp_q.push_back({m_ch, m_out});
            end else if (rd) begin
                m_valid = 0;
                m_fd    = 0;
            end
            if (!m) m_count = 0;
        end
        @(posedge clk);
        #1;
        check("model_out", out, m_out);
        check("model_ch", out_ch, m_ch);
        check("model_valid", out_valid, m_valid);
        check("model_fd", frame_done, m_fd);
    endtask

    task automatic expect4(input string tag, input logic [WIDTH-1:0] eo, input logic [SELW-1:0] ec,
                           input bit ev, input bit efd);
        check({tag, "_out"}, out, eo);
        check({tag, "_ch"}, out_ch, ec);
        check({tag, "_valid"}, out_valid, ev);
        check({tag, "_fd"}, frame_done, efd);
    endtask

    task automatic step3(input string tag, input bit r, input bit e, input bit m,
                         input logic [SELW-1:0] s, input logic [WIDTH-1:0] eo,
                         input logic [SELW-1:0] ec, input bit ev, input bit efd);
        rst3 = r; en3 = e; mode3 = m; sel3 = s; din3 = D3; ready3 = 1;
        @(posedge clk);
        #1;
        check({tag, "_out"}, out3, eo);
        check({tag, "_ch"}, ch3, ec);
        check({tag, "_valid"}, valid3, ev);
        check({tag, "_fd"}, fd3, efd);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit               e, m;
        logic [SELW-1:0]  s;
        logic [WIDTH-1:0] eo;
        logic [SELW-1:0]  ec;
        bit               efd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit r_mode;
        rst = 1; en = 0; mode = 0; sel = '0; din = D4; out_ready = 1;
        rst3 = 1; en3 = 0; mode3 = 0; sel3 = '0; din3 = D3; ready3 = 1;

        // manual sweep, then a scan frame and a half
        vecs[0] = '{1, 0, 2'd0, 8'h11, 2'd0, 0};
        vecs[1] = '{1, 0, 2'd1, 8'h22, 2'd1, 0};
        vecs[2] = '{1, 0, 2'd2, 8'h33, 2'd2, 0};
        vecs[3] = '{1, 0, 2'd3, 8'h44, 2'd3, 0};
        vecs[4] = '{1, 1, 2'd2, 8'h11, 2'd0, 0};
        vecs[5] = '{1, 1, 2'd0, 8'h22, 2'd1, 0};
        vecs[6] = '{1, 1, 2'd3, 8'h33, 2'd2, 0};
        vecs[7] = '{1, 1, 2'd1, 8'h44, 2'd3, 1};
        vecs[8] = '{1, 1, 2'd0, 8'h11, 2'd0, 0};
        vecs[9] = '{1, 1, 2'd2, 8'h22, 2'd1, 0};

        step(1, 1, 1, 2'd2, D4, 1);
        expect4("reset", 8'h00, 2'd0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, vecs[i].e, vecs[i].m, vecs[i].s, D4, 1);
            expect4($sformatf("vec%0d", i), vecs[i].eo, vecs[i].ec, 1, vecs[i].efd);
        end

        // backpressure at ch1
        step(1, 0, 0, 2'd0, D4, 1);
        step(0, 1, 1, 2'd0, D4, 1);
        step(0, 1, 1, 2'd0, D4, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 2'd0, D4, 0);
            expect4("stall_hold", 8'h22, 2'd1, 1, 0);
        end
        step(0, 1, 1, 2'd0, D4, 1);
        expect4("stall_resume2", 8'h33, 2'd2, 1, 0);
        step(0, 1, 1, 2'd0, D4, 1);
        expect4("stall_resume3", 8'h44, 2'd3, 1, 1);

        // mode switch mid-frame restarts the scan at ch0
        step(1, 0, 0, 2'd0, D4, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 2'd0, D4, 1);
        expect4("switch_scan2", 8'h33, 2'd2, 1, 0);
        step(0, 1, 0, 2'd3, D4, 1);
        expect4("switch_manual3", 8'h44, 2'd3, 1, 0);
        step(0, 1, 1, 2'd3, D4, 1);
        expect4("switch_rescan0", 8'h11, 2'd0, 1, 0);

        // reset mid-frame
        step(0, 1, 1, 2'd0, D4, 1);
        step(0, 1, 1, 2'd0, D4, 1);
        expect4("midrst_pre", 8'h33, 2'd2, 1, 0);
        step(1, 1, 1, 2'd0, D4, 1);
        expect4("midrst", 8'h00, 2'd0, 0, 0);
        step(0, 1, 1, 2'd0, D4, 1);
        expect4("midrst_restart", 8'h11, 2'd0, 1, 0);

        // drain, idle, then scan resumes where it stopped
        step(0, 0, 1, 2'd0, D4, 1);
        expect4("drain", 8'h11, 2'd0, 0, 0);
        step(0, 0, 1, 2'd0, D4, 0);
        expect4("idle", 8'h11, 2'd0, 0, 0);
        step(0, 1, 1, 2'd0, D4, 1);
        expect4("resume_ch1", 8'h22, 2'd1, 1, 0);

        // mode dropped while stalled: item held, next capture starts at ch0
        step(0, 1, 0, 2'd2, D4, 0);
        expect4("stall_modechg", 8'h22, 2'd1, 1, 0);
        step(0, 1, 1, 2'd2, D4, 1);
        expect4("after_modechg", 8'h11, 2'd0, 1, 0);

        // randomized traffic against the model
        r_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) r_mode = ~r_mode;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, r_mode,
                 SELW'($urandom_range(0, N - 1)), {$urandom, $urandom} , $urandom_range(0, 9) < 7);
        end

        // N=3 instance: out-of-range select and three-channel scan wrap
        step3("n3_reset", 1, 0, 0, 2'd0, 8'h00, 2'd0, 0, 0);
        step3("n3_oor", 0, 1, 0, 2'd3, 8'h00, 2'd3, 1, 0);
        step3("n3_scan0", 0, 1, 1, 2'd0, 8'h11, 2'd0, 1, 0);
        step3("n3_scan1", 0, 1, 1, 2'd0, 8'h22, 2'd1, 1, 0);
        step3("n3_scan2", 0, 1, 1, 2'd0, 8'h33, 2'd2, 1, 1);
        step3("n3_wrap0", 0, 1, 1, 2'd0, 8'h11, 2'd0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
